// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants and types for the host-command receiver:
// frame header bytes, command codes, FSM encodings and the command payload.
package uart_cmd_rx_pkg;

  localparam logic [7:0] HDR0       = 8'h55;
  localparam logic [7:0] HDR1       = 8'hAA;
  localparam logic [7:0] CMD_COLOR  = 8'h01;
  localparam logic [7:0] CMD_TARGET = 8'h02;
  localparam logic [7:0] CMD_DETECT = 8'h03;
  localparam int unsigned FRAME_LEN = 5;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  typedef enum logic [2:0] {
    P_H0,
    P_H1,
    P_CMD,
    P_DAT,
    P_SUM
  } parser_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] data;
  } cmd_t;

  // Frame checksum: CMD + DATA modulo 256.
  function automatic logic [7:0] frame_sum(input logic [7:0] code, input logic [7:0] data);
    return 8'(code + data);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, mid-bit sampling baud counter
// and byte FSM producing rx_byte/rx_byte_vld and a stop-bit error pulse.
module uart_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       stop_err
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;

  // Synchroniser resets to 1 so the line reads idle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = RX_START;
      end
      // Re-check the start bit at its centre to reject glitches.
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            vld_d   = 1'b1;
            byte_d  = shift_q;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_HI: begin
        if (rx_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte     = byte_q;
  assign rx_byte_vld = vld_q;
  assign stop_err    = err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Host-command receiver: frames UART bytes into 55 AA CMD DATA SUM packets
// and drives color/target/detect controls, with intra-frame timeout.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned TIMEOUT_CYC = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       cmd_vld,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_data,
  output logic [1:0] color_sel,
  output logic [2:0] target_cnt,
  output logic       detect_start,
  output logic       frame_err
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [7:0] byte_w;
  logic       byte_vld_w, stop_err_w;

  uart_rx_byte #(.DIV(DIV)) u_rx_byte (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_pin      (rx_pin),
    .rx_byte     (byte_w),
    .rx_byte_vld (byte_vld_w),
    .stop_err    (stop_err_w)
  );

  parser_state_e   p_q, p_d;
  logic [TO_W-1:0] to_q, to_d;
  cmd_t            pend_q, pend_d;
  cmd_t            cmd_q, cmd_d;
  logic [1:0]      color_q, color_d;
  logic [2:0]      target_q, target_d;
  logic            cmd_vld_q, cmd_vld_d;
  logic            detect_q, detect_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q       <= P_H0;
      to_q      <= '0;
      pend_q    <= '0;
      cmd_q     <= '0;
      color_q   <= '0;
      target_q  <= '0;
      cmd_vld_q <= 1'b0;
      detect_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      p_q       <= p_d;
      to_q      <= to_d;
      pend_q    <= pend_d;
      cmd_q     <= cmd_d;
      color_q   <= color_d;
      target_q  <= target_d;
      cmd_vld_q <= cmd_vld_d;
      detect_q  <= detect_d;
      ferr_q    <= ferr_d;
    end
  end

  // Byte events, stop errors and timeouts are mutually exclusive per clk,
  // so a single frame_err source is chosen at a time.
  always_comb begin
    p_d       = p_q;
    to_d      = to_q;
    pend_d    = pend_q;
    cmd_d     = cmd_q;
    color_d   = color_q;
    target_d  = target_q;
    cmd_vld_d = 1'b0;
    detect_d  = 1'b0;
    ferr_d    = 1'b0;
    if (byte_vld_w) begin
      to_d = '0;
      unique case (p_q)
        P_H0:  if (byte_w == HDR0) p_d = P_H1;
        P_H1: begin
          if (byte_w == HDR1)      p_d = P_CMD;
          else if (byte_w != HDR0) p_d = P_H0;
        end
        P_CMD: begin
          pend_d.code = byte_w;
          p_d         = P_DAT;
        end
        P_DAT: begin
          pend_d.data = byte_w;
          p_d         = P_SUM;
        end
        P_SUM: begin
          p_d = P_H0;
          if (byte_w == frame_sum(pend_q.code, pend_q.data)) begin
            cmd_vld_d = 1'b1;
            cmd_d     = pend_q;
            if (pend_q.code == CMD_COLOR)  color_d  = pend_q.data[1:0];
            if (pend_q.code == CMD_TARGET) target_d = pend_q.data[2:0];
            if (pend_q.code == CMD_DETECT) detect_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: p_d = P_H0;
      endcase
    end else if (stop_err_w) begin
      ferr_d = 1'b1;
      p_d    = P_H0;
      to_d   = '0;
    end else if (p_q != P_H0) begin
      if (to_q == TO_LAST) begin
        ferr_d = 1'b1;
        p_d    = P_H0;
        to_d   = '0;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  assign rx_byte      = byte_w;
  assign rx_byte_vld  = byte_vld_w;
  assign cmd_vld      = cmd_vld_q;
  assign cmd_code     = cmd_q.code;
  assign cmd_data     = cmd_q.data;
  assign color_sel    = color_q;
  assign target_cnt   = target_q;
  assign detect_start = detect_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Self-checking bench for uart_cmd_rx: directed frame table, multi-cycle
// corner sequences and a randomized byte stream against a frame-scanning model.
module tb_uart_cmd_rx;

  localparam int unsigned TB_CLK  = 1_600_000;
  localparam int unsigned TB_BAUD = 100_000;
  localparam int unsigned TB_TO   = 2000;
  localparam int unsigned DIV     = TB_CLK / TB_BAUD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_byte_vld;
  logic       cmd_vld;
  logic [7:0] cmd_code;
  logic [7:0] cmd_data;
  logic [1:0] color_sel;
  logic [2:0] target_cnt;
  logic       detect_start;
  logic       frame_err;

  uart_cmd_rx #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD), .TIMEOUT_CYC(TB_TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_pin       (rx_pin),
    .rx_byte      (rx_byte),
    .rx_byte_vld  (rx_byte_vld),
    .cmd_vld      (cmd_vld),
    .cmd_code     (cmd_code),
    .cmd_data     (cmd_data),
    .color_sel    (color_sel),
    .target_cnt   (target_cnt),
    .detect_start (detect_start),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] data;
    logic [1:0] color;
    logic [2:0] target;
    logic       det;
  } ev_t;

  ev_t ev_q[$];
  int  n_bv = 0, n_fe = 0, n_dv = 0, n_det = 0;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_byte_vld) n_bv++;
    if (frame_err) n_fe++;
    if (detect_start) begin
      n_det++;
      check("detect_with_cmd_vld", 32'(cmd_vld), 32'd1);
    end
    if (cmd_vld || frame_err) check("cmd_vld_frame_err_excl", 32'(cmd_vld && frame_err), 32'd0);
    if (cmd_vld) begin
      n_dv++;
      ev_q.push_back('{code: cmd_code, data: cmd_data, color: color_sel,
                       target: target_cnt, det: detect_start});
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_pin = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx_pin = stop_bit;
    repeat (DIV) @(posedge clk);
    rx_pin = 1'b1;
    if (!stop_bit) repeat (2) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4 * DIV) @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    int         n;
    logic [7:0] b [6];
    int         dv, fe, det;
    logic [1:0] color;
    logic [2:0] target;
    logic [7:0] code, data;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] a0, a1, a2, a3, a4, a5,
                              input int dv, fe, det, input logic [1:0] col,
                              input logic [2:0] tgt, input logic [7:0] code, data);
    vec_t v;
    v.n = n;
    v.b[0] = a0; v.b[1] = a1; v.b[2] = a2; v.b[3] = a3; v.b[4] = a4; v.b[5] = a5;
    v.dv = dv; v.fe = fe; v.det = det;
    v.color = col; v.target = tgt; v.code = code; v.data = data;
    return v;
  endfunction

  // Reference: scan the stream for the earliest 55 AA pair, take the next three
  // bytes positionally, judge the checksum, resume after the frame.
  logic [7:0] exp_code[$], exp_data[$];
  int         exp_err;
  bit         exp_partial;

  task automatic model(input logic [7:0] s[$]);
    int k = 0;
    int j;
    exp_code.delete();
    exp_data.delete();
    exp_err = 0;
    exp_partial = 0;
    forever begin
      j = -1;
      for (int i = k; i + 1 < s.size(); i++)
        if (s[i] == 8'h55 && s[i+1] == 8'hAA) begin j = i; break; end
      if (j < 0) begin
        exp_partial = (s.size() > k) && (s[s.size()-1] == 8'h55);
        break;
      end
      if (j + 4 >= s.size()) begin exp_partial = 1; break; end
      if (s[j+4] == 8'((s[j+2] + s[j+3]) % 256)) begin
        exp_code.push_back(s[j+2]);
        exp_data.push_back(s[j+3]);
      end else begin
        exp_err++;
      end
      k = j + 5;
    end
  endtask

  vec_t tbl[7];

  initial begin
    int bv0, fe0, dv0, det0;
    logic [7:0] stream[$];
    logic [1:0] m_col;
    logic [2:0] m_tgt;
    logic [7:0] jb, cd, dt, sm;

    tbl[0] = mk(5, 8'h55, 8'hAA, 8'h01, 8'h02, 8'h03, 8'h00, 1, 0, 0, 2'd2, 3'd0, 8'h01, 8'h02);
    tbl[1] = mk(5, 8'h55, 8'hAA, 8'h02, 8'h05, 8'h07, 8'h00, 1, 0, 0, 2'd2, 3'd5, 8'h02, 8'h05);
    tbl[2] = mk(5, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h03, 8'h00, 1, 0, 1, 2'd2, 3'd5, 8'h03, 8'h00);
    tbl[3] = mk(5, 8'h55, 8'hAA, 8'h01, 8'h01, 8'hFF, 8'h00, 0, 1, 0, 2'd2, 3'd5, 8'h03, 8'h00);
    tbl[4] = mk(6, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h03, 8'h04, 1, 0, 0, 2'd3, 3'd5, 8'h01, 8'h03);
    tbl[5] = mk(5, 8'h55, 8'hAA, 8'h02, 8'h0E, 8'h10, 8'h00, 1, 0, 0, 2'd3, 3'd6, 8'h02, 8'h0E);
    tbl[6] = mk(5, 8'h55, 8'hAA, 8'h07, 8'h09, 8'h10, 8'h00, 1, 0, 0, 2'd3, 3'd6, 8'h07, 8'h09);

    do_reset();
    @(negedge clk);
    check("reset_rx_byte", 32'(rx_byte), 32'h0);
    check("reset_cmd_code", 32'(cmd_code), 32'h0);
    check("reset_cmd_data", 32'(cmd_data), 32'h0);
    check("reset_color", 32'(color_sel), 32'h0);
    check("reset_target", 32'(target_cnt), 32'h0);
    check("reset_pulses", 32'({rx_byte_vld, cmd_vld, detect_start, frame_err}), 32'h0);

    // Directed frames.
    for (int r = 0; r < 7; r++) begin
      dv0 = n_dv; fe0 = n_fe; det0 = n_det;
      for (int i = 0; i < tbl[r].n; i++) send_byte(tbl[r].b[i], 1'b1);
      settle();
      @(negedge clk);
      check($sformatf("row%0d_cmd_vld", r), 32'(n_dv - dv0), 32'(tbl[r].dv));
      check($sformatf("row%0d_frame_err", r), 32'(n_fe - fe0), 32'(tbl[r].fe));
      check($sformatf("row%0d_detect", r), 32'(n_det - det0), 32'(tbl[r].det));
      check($sformatf("row%0d_color", r), 32'(color_sel), 32'(tbl[r].color));
      check($sformatf("row%0d_target", r), 32'(target_cnt), 32'(tbl[r].target));
      check($sformatf("row%0d_code", r), 32'(cmd_code), 32'(tbl[r].code));
      check($sformatf("row%0d_data", r), 32'(cmd_data), 32'(tbl[r].data));
      check($sformatf("row%0d_rx_byte", r), 32'(rx_byte), 32'(tbl[r].b[tbl[r].n-1]));
    end

    // Intra-frame timeout, then trailing bytes must not complete anything.
    dv0 = n_dv; fe0 = n_fe;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
    repeat (TB_TO + 100) @(posedge clk);
    check("timeout_frame_err", 32'(n_fe - fe0), 32'd1);
    fe0 = n_fe;
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    settle();
    check("timeout_no_cmd_vld", 32'(n_dv - dv0), 32'd0);
    check("timeout_no_extra_err", 32'(n_fe - fe0), 32'd0);

    // Gap just under the timeout keeps the frame alive.
    dv0 = n_dv; fe0 = n_fe;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
    repeat (TB_TO - 12 * DIV) @(posedge clk);
    send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    settle();
    check("near_timeout_cmd_vld", 32'(n_dv - dv0), 32'd1);
    check("near_timeout_no_err", 32'(n_fe - fe0), 32'd0);
    check("near_timeout_color", 32'(color_sel), 32'd2);

    // Short low glitch is rejected as a false start.
    bv0 = n_bv; fe0 = n_fe;
    rx_pin = 1'b0;
    repeat (DIV / 2 - 3) @(posedge clk);
    rx_pin = 1'b1;
    repeat (12 * DIV) @(posedge clk);
    check("glitch_no_byte", 32'(n_bv - bv0), 32'd0);
    check("glitch_no_err", 32'(n_fe - fe0), 32'd0);

    // Stop bit low while idle: byte dropped, one frame_err.
    bv0 = n_bv; fe0 = n_fe;
    send_byte(8'h3C, 1'b0);
    settle();
    check("stop0_no_byte", 32'(n_bv - bv0), 32'd0);
    check("stop0_frame_err", 32'(n_fe - fe0), 32'd1);

    // Stop bit low mid-frame aborts it with a single frame_err.
    dv0 = n_dv; fe0 = n_fe;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b1); send_byte(8'h01, 1'b1);
    settle();
    check("stop0_mid_err_once", 32'(n_fe - fe0), 32'd1);
    check("stop0_mid_no_cmd", 32'(n_dv - dv0), 32'd0);
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    settle();
    check("stop0_recover_cmd", 32'(n_dv - dv0), 32'd1);
    check("stop0_recover_color", 32'(color_sel), 32'd0);

    // Reset mid-frame: outputs clear, the partial frame never completes.
    dv0 = n_dv;
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h02, 1'b1);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", 32'({rx_byte, cmd_code, cmd_data, color_sel, target_cnt}), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    send_byte(8'h06, 1'b1); send_byte(8'h08, 1'b1);
    settle();
    check("midrst_no_cmd", 32'(n_dv - dv0), 32'd0);
    send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h06, 1'b1); send_byte(8'h08, 1'b1);
    settle();
    check("midrst_next_cmd", 32'(n_dv - dv0), 32'd1);
    check("midrst_next_target", 32'(target_cnt), 32'd6);

    // Randomized stream against the model, from a clean reset.
    do_reset();
    ev_q.delete();
    stream.delete();
    for (int f = 0; f < 24; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == 8'h55) jb = 8'h54;
        stream.push_back(jb);
      end
      cd = 8'($urandom_range(0, 4));
      dt = 8'($urandom_range(0, 255));
      sm = 8'((cd + dt) % 256);
      if ($urandom_range(0, 3) == 0) sm = sm ^ 8'($urandom_range(1, 255));
      stream.push_back(8'h55); stream.push_back(8'hAA);
      stream.push_back(cd); stream.push_back(dt); stream.push_back(sm);
    end
    model(stream);
    bv0 = n_bv; fe0 = n_fe;
    foreach (stream[i]) begin
      send_byte(stream[i], 1'b1);
      repeat ($urandom_range(0, 40)) @(posedge clk);
    end
    repeat (TB_TO + 200) @(posedge clk);
    check("rand_byte_count", 32'(n_bv - bv0), 32'(stream.size()));
    check("rand_cmd_count", 32'(ev_q.size()), 32'(exp_code.size()));
    check("rand_err_count", 32'(n_fe - fe0), 32'(exp_err + int'(exp_partial)));
    m_col = 2'd0;
    m_tgt = 3'd0;
    for (int i = 0; i < ev_q.size() && i < exp_code.size(); i++) begin
      if (exp_code[i] == 8'h01) m_col = exp_data[i][1:0];
      if (exp_code[i] == 8'h02) m_tgt = exp_data[i][2:0];
      check($sformatf("rand%0d_code", i), 32'(ev_q[i].code), 32'(exp_code[i]));
      check($sformatf("rand%0d_data", i), 32'(ev_q[i].data), 32'(exp_data[i]));
      check($sformatf("rand%0d_color", i), 32'(ev_q[i].color), 32'(m_col));
      check($sformatf("rand%0d_target", i), 32'(ev_q[i].target), 32'(m_tgt));
      check($sformatf("rand%0d_detect", i), 32'(ev_q[i].det), 32'(exp_code[i] == 8'h03));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
